// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
//   size_e  : access size codes (byte / half / word / reserved)
//   state_e : controller FSM states
//   cmd_t   : one requester's command as presented on its port group
//   lat_t   : the part of the winning command kept for the response phase
//   out_t   : every registered output of the controller, reset as a unit
package dmem_access_ctrl_pkg;

  localparam logic [31:0] DMEM_BASE_DEF  = 32'h0010_0000;
  localparam int          DMEM_BYTES_DEF = 65536;
  localparam int          MEM_AW         = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic       dbg;    // winner: 0 = core, 1 = debug loader
    logic       we;
    size_e      size;
    logic       uns;
    logic [1:0] lo;     // byte offset within the word
    logic       fault;
  } lat_t;

  typedef struct packed {
    logic              core_ready;
    logic              core_rvalid;
    logic              core_fault;
    logic [31:0]       core_rdata;
    logic              dbg_ready;
    logic              dbg_rvalid;
    logic              dbg_fault;
    logic [31:0]       dbg_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
  } out_t;

  function automatic logic [3:0] lane_be(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so mem_be alone picks the target.
  function automatic logic [31:0] lane_wdata(size_e sz, logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_format.sv
// Load data formatter (combinational).
//   word_i : raw 32-bit word read from memory
//   lo_i   : byte offset of the access within the word
//   size_i : access size
//   uns_i  : 1 = zero-extend, 0 = sign-extend
//   data_o : right-aligned, extended load result
module dmem_load_format
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lo_i,
  input  size_e       size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  always_comb begin
    sh = word_i >> {lo_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & sh[7]}},  sh[7:0]};
      SZ_HALF: data_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates the core LSU and the debug
// loader round-robin onto a single-ported data memory, one transaction at
// a time (IDLE -> ISSUE -> WAIT -> RESP, faults skip WAIT).
//   clk, rst                 : clock, synchronous active-high reset
//   core_* / dbg_*  (in)     : req, we, size, uns, addr, wdata
//   core_* / dbg_*  (out)    : ready pulse, rvalid pulse, rdata, fault
//   mem_en/we/be/addr/wdata  : memory command, one cycle in ISSUE
//   mem_rdata                : read word, valid the cycle after mem_en
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_DEF,
  parameter int          MEM_BYTES = DMEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_size,
  input  logic              core_uns,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_ready,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  output logic              core_fault,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_uns,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  lat_t        lat_q, lat_d;
  out_t        out_q, out_d;
  logic        last_dbg_q;   // 1 = debug granted last; reset value favours core
  cmd_t        core_cmd, dbg_cmd, sel_cmd;
  logic        sel_dbg, grant, sel_fault, resp;
  logic [31:0] offset, load_data;

  dmem_load_format u_fmt (
    .word_i (mem_rdata),
    .lo_i   (lat_q.lo),
    .size_i (lat_q.size),
    .uns_i  (lat_q.uns),
    .data_o (load_data)
  );

  always_comb begin
    core_cmd = '{we: core_we, size: size_e'(core_size), uns: core_uns,
                 addr: core_addr, wdata: core_wdata};
    dbg_cmd  = '{we: dbg_we, size: size_e'(dbg_size), uns: dbg_uns,
                 addr: dbg_addr, wdata: dbg_wdata};
    // Debug wins only when alone, or when both ask and core went last.
    sel_dbg  = dbg_req & (~core_req | ~last_dbg_q);
    sel_cmd  = sel_dbg ? dbg_cmd : core_cmd;
    grant    = (state_q == ST_IDLE) & (core_req | dbg_req);
    // Unsigned compare also catches addresses below the base (wraps high).
    offset   = sel_cmd.addr - BASE_ADDR;
    sel_fault = (offset >= MEM_LIMIT)
              | (sel_cmd.size == SZ_RSVD)
              | ((sel_cmd.size == SZ_HALF) & sel_cmd.addr[0])
              | ((sel_cmd.size == SZ_WORD) & (|sel_cmd.addr[1:0]));

    lat_d = '{dbg: sel_dbg, we: sel_cmd.we, size: sel_cmd.size, uns: sel_cmd.uns,
              lo: sel_cmd.addr[1:0], fault: sel_fault};

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: state_d = lat_q.fault ? ST_RESP : ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered, so each is computed one state early:
    // ISSUE outputs on the IDLE grant, RESP outputs on the way into RESP.
    resp  = (state_q == ST_WAIT) | ((state_q == ST_ISSUE) & lat_q.fault);
    out_d = '0;
    out_d.core_ready = grant & ~sel_dbg;
    out_d.dbg_ready  = grant &  sel_dbg;
    out_d.mem_en     = grant & ~sel_fault;
    if (out_d.mem_en) begin
      out_d.mem_we    = sel_cmd.we;
      out_d.mem_be    = lane_be(sel_cmd.size, sel_cmd.addr[1:0]);
      out_d.mem_addr  = {offset[MEM_AW-1:2], 2'b00};
      out_d.mem_wdata = sel_cmd.we ? lane_wdata(sel_cmd.size, sel_cmd.wdata) : '0;
    end
    if (resp) begin
      if (lat_q.dbg) begin
        out_d.dbg_rvalid = 1'b1;
        out_d.dbg_fault  = lat_q.fault;
        out_d.dbg_rdata  = (lat_q.fault | lat_q.we) ? '0 : load_data;
      end else begin
        out_d.core_rvalid = 1'b1;
        out_d.core_fault  = lat_q.fault;
        out_d.core_rdata  = (lat_q.fault | lat_q.we) ? '0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      out_q      <= '0;
      last_dbg_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (grant) begin
        lat_q      <= lat_d;
        last_dbg_q <= sel_dbg;
      end
    end
  end

  assign core_ready  = out_q.core_ready;
  assign core_rvalid = out_q.core_rvalid;
  assign core_fault  = out_q.core_fault;
  assign core_rdata  = out_q.core_rdata;
  assign dbg_ready   = out_q.dbg_ready;
  assign dbg_rvalid  = out_q.dbg_rvalid;
  assign dbg_fault   = out_q.dbg_fault;
  assign dbg_rdata   = out_q.dbg_rdata;
  assign mem_en      = out_q.mem_en;
  assign mem_we      = out_q.mem_we;
  assign mem_be      = out_q.mem_be;
  assign mem_addr    = out_q.mem_addr;
  assign mem_wdata   = out_q.mem_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a word-wide memory model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_uns;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata;
  logic        core_ready, core_rvalid, core_fault;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we, dbg_uns;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ready, dbg_rvalid, dbg_fault;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:16383];

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // results of the last transaction
  int          r_rdy_n, r_val_n;
  logic [31:0] r_rdata;
  logic        r_fault, r_en, r_other;
  logic [3:0]  r_be;
  logic [15:0] r_maddr;
  logic [31:0] r_wdata;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_size(core_size), .core_uns(core_uns),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ready(core_ready),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_fault(core_fault),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_uns(dbg_uns),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_fault(dbg_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[15:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr[15:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction from one requester; cycle numbers count posedges from
  // the edge at which IDLE samples the request (that edge is number 1's start).
  task automatic txn(input bit dbg, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    if (dbg) begin
      dbg_req = 1; dbg_we = we; dbg_size = sz; dbg_uns = uns; dbg_addr = a; dbg_wdata = wd;
    end else begin
      core_req = 1; core_we = we; core_size = sz; core_uns = uns; core_addr = a; core_wdata = wd;
    end
    r_rdy_n = -1; r_val_n = -1; r_rdata = 32'hxxxx_xxxx; r_fault = 1'bx;
    r_en = 0; r_other = 0; r_be = 0; r_maddr = 0; r_wdata = 0;
    for (int n = 1; n <= 20; n++) begin
      if (r_val_n >= 0) break;
      @(posedge clk); #1;
      if (mem_en) begin r_en = 1; r_be = mem_be; r_maddr = mem_addr; r_wdata = mem_wdata; end
      if (dbg ? dbg_ready : core_ready) begin
        r_rdy_n = n;
        if (dbg) dbg_req = 0; else core_req = 0;
      end
      if (dbg ? (core_ready | core_rvalid) : (dbg_ready | dbg_rvalid)) r_other = 1;
      if (dbg ? dbg_rvalid : core_rvalid) begin
        r_val_n = n;
        r_rdata = dbg ? dbg_rdata : core_rdata;
        r_fault = dbg ? dbg_fault : core_fault;
      end
    end
    core_req = 0; dbg_req = 0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({core_ready, core_rvalid, core_fault, dbg_ready, dbg_rvalid,
                        dbg_fault, mem_en, mem_we, mem_be}), 32'h0);
    chk("rst_data", core_rdata | dbg_rdata | mem_wdata | 32'(mem_addr), 32'h0);
    @(negedge clk); rst = 0;
  endtask

  int          gn [4];
  bit          gw [4];
  int          g;
  bit          seen;

  initial begin
    rst = 0; mem_rdata = 0;
    core_req = 0; core_we = 0; core_size = 0; core_uns = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0;  dbg_we = 0;  dbg_size = 0;  dbg_uns = 0;  dbg_addr = 0;  dbg_wdata = 0;
    do_reset();

    // sw / lw at base+4
    txn(0, 1, 2'd2, 0, 32'h0010_0004, 32'hDEAD_BEEF);
    chk("sw_ready_n", r_rdy_n, 1);
    chk("sw_rvalid_n", r_val_n, 3);
    chk("sw_be", r_be, 4'b1111);
    chk("sw_maddr", r_maddr, 16'h0004);
    chk("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    chk("sw_rdata0", r_rdata, 0);
    txn(0, 0, 2'd2, 0, 32'h0010_0004, 0);
    chk("lw_rvalid_n", r_val_n, 3);
    chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("lw_be", r_be, 4'b1111);
    chk("lw_maddr", r_maddr, 16'h0004);
    chk("lw_fault", r_fault, 0);

    // byte lane 3
    txn(0, 1, 2'd0, 0, 32'h0010_0007, 32'h0000_0080);
    chk("sb_be", r_be, 4'b1000);
    chk("sb_wdata", r_wdata, 32'h8080_8080);
    txn(0, 0, 2'd0, 0, 32'h0010_0007, 0);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    txn(0, 0, 2'd0, 1, 32'h0010_0007, 0);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);

    // faults
    txn(0, 0, 2'd1, 0, 32'h0010_0001, 0);
    chk("lh_mis_fault", r_fault, 1);
    chk("lh_mis_rvalid_n", r_val_n, 2);
    chk("lh_mis_en", r_en, 0);
    chk("lh_mis_rdata", r_rdata, 0);
    txn(0, 0, 2'd2, 0, 32'h0000_FFFC, 0);
    chk("below_base_fault", r_fault, 1);
    txn(0, 0, 2'd0, 0, 32'h0011_0000, 0);
    chk("past_end_fault", r_fault, 1);
    txn(0, 0, 2'd3, 0, 32'h0010_0000, 0);
    chk("size3_fault", r_fault, 1);
    txn(0, 1, 2'd2, 0, 32'h0010_0006, 32'h1111_1111);
    chk("sw_mis_fault", r_fault, 1);
    chk("sw_mis_en", r_en, 0);
    txn(0, 0, 2'd2, 0, 32'h0010_0004, 0);
    chk("no_write_on_fault", r_rdata, 32'h80AD_BEEF);

    // last byte of the window is in range
    txn(0, 1, 2'd0, 0, 32'h0010_FFFF, 32'h0000_005A);
    chk("top_byte_fault", r_fault, 0);
    chk("top_byte_maddr", r_maddr, 16'hFFFC);
    txn(0, 0, 2'd0, 1, 32'h0010_FFFF, 0);
    chk("top_byte_rdata", r_rdata, 32'h0000_005A);

    // halfword upper lane
    txn(0, 1, 2'd1, 0, 32'h0010_0002, 32'h1234_ABCD);
    chk("sh_be", r_be, 4'b1100);
    chk("sh_wdata", r_wdata, 32'hABCD_ABCD);
    txn(0, 0, 2'd1, 1, 32'h0010_0002, 0);
    chk("lhu_rdata", r_rdata, 32'h0000_ABCD);
    txn(0, 0, 2'd1, 0, 32'h0010_0002, 0);
    chk("lh_rdata", r_rdata, 32'hFFFF_ABCD);

    // debug alone, twice in a row: a sole requester always wins
    txn(1, 0, 2'd2, 0, 32'h0010_0004, 0);
    chk("dbg1_ready_n", r_rdy_n, 1);
    chk("dbg1_rdata", r_rdata, 32'h80AD_BEEF);
    chk("dbg1_core_quiet", r_other, 0);
    txn(1, 0, 2'd0, 1, 32'h0010_0003, 0);
    chk("dbg2_ready_n", r_rdy_n, 1);
    chk("dbg2_rdata", r_rdata, 32'h0000_00AB);

    // both requesting continuously after reset: core, dbg, core, dbg
    do_reset();
    @(negedge clk);
    core_req = 1; core_we = 0; core_size = 2'd2; core_uns = 0; core_addr = 32'h0010_0004;
    dbg_req  = 1; dbg_we  = 0; dbg_size  = 2'd2; dbg_uns  = 0; dbg_addr  = 32'h0010_0004;
    g = 0; seen = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (core_ready & dbg_ready) seen = 1;
      if ((core_ready | dbg_ready) && g < 4) begin
        gn[g] = n; gw[g] = dbg_ready; g++;
        if (g == 4) begin core_req = 0; dbg_req = 0; end
      end
    end
    core_req = 0; dbg_req = 0;
    chk("arb_count", g, 4);
    chk("arb_both_ready", seen, 0);
    chk("arb_order", {28'h0, gw[0], gw[1], gw[2], gw[3]}, 32'b0101);
    chk("arb_n0", gn[0], 1);
    chk("arb_n1", gn[1], 5);
    chk("arb_n2", gn[2], 9);
    chk("arb_n3", gn[3], 13);

    // reset while a debug load sits in WAIT
    @(negedge clk);
    dbg_req = 1; dbg_we = 0; dbg_size = 2'd2; dbg_addr = 32'h0010_0004;
    @(posedge clk); #1;
    chk("abort_dbg_ready", dbg_ready, 1);
    dbg_req = 0;
    @(posedge clk); #1;           // now in WAIT
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("abort_ctl", 32'({core_ready, core_rvalid, core_fault, dbg_ready, dbg_rvalid,
                          dbg_fault, mem_en, mem_we, mem_be}), 32'h0);
    chk("abort_data", core_rdata | dbg_rdata | mem_wdata | 32'(mem_addr), 32'h0);
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (dbg_rvalid | core_rvalid | mem_en) seen = 1; end
    chk("abort_quiet", seen, 0);
    @(negedge clk); rst = 0;
    txn(0, 0, 2'd2, 0, 32'h0010_0004, 0);
    chk("post_rst_ready_n", r_rdy_n, 1);
    chk("post_rst_rdata", r_rdata, 32'h80AD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
